// File: rtl/dram_pkg.sv
// Shared types for the open-row DRAM command sequencer.
// Covers the state encoding, the pin-level command encoding and the default field widths.
package dram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ACT,
    RDCMD,
    RDWAIT,
    WRCMD,
    WRREC,
    RSP
  } state_t;

  // {CSn, RASn, CASn, WEn}
  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_NOP   = 4'b0111;
  localparam cmd_t CMD_PRE   = 4'b0010;
  localparam cmd_t CMD_ACT   = 4'b0011;
  localparam cmd_t CMD_RD    = 4'b0101;
  localparam cmd_t CMD_WR    = 4'b0100;
  localparam cmd_t CMD_DESEL = 4'b1111;

  // The request address is {row, col}, and each field is ADDR_ROW_W bits wide.
  localparam int ADDR_ROW_W = 11;
  localparam int TMR_W      = 8;

endpackage

// File: rtl/dram_timer.sv
// Loadable down-counter with a zero flag.
// A single instance times the PRE, ACT, RDWAIT and WRREC phases.
module dram_timer
  import dram_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dram_cmd_seq.sv
// Open-row DRAM command sequencer. Single-word requests are turned into PRE/ACT/RD/WR
// pin sequences, and a one-cycle response pulse is returned. All outputs are registered.
module dram_cmd_seq
  import dram_pkg::*;
#(
  parameter int T_RP   = 2,
  parameter int T_RCD  = 2,
  parameter int T_CL   = 3,
  parameter int T_WR   = 1,
  parameter int DATA_W = 32,
  parameter int ROW_W  = ADDR_ROW_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [2*ROW_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  input  logic [DATA_W-1:0]   DRAM_Q,
  output logic                DRAM_CSn,
  output logic                DRAM_RASn,
  output logic                DRAM_CASn,
  output logic                DRAM_WEn,
  output logic [ROW_W-1:0]    DRAM_A,
  output logic [DATA_W-1:0]   DRAM_D
);

  state_t              state_q, state_d;
  logic                row_open_q, row_open_d;
  logic [ROW_W-1:0]    open_row_q, open_row_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ROW_W-1:0]    col_q, col_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  cmd_t                cmd_q, cmd_d;
  logic [ROW_W-1:0]    a_q, a_d;
  logic [DATA_W-1:0]   d_q, d_d;
  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic                tmr_load;
  logic [TMR_W-1:0]    tmr_val;
  logic                tmr_zero;

  logic [ROW_W-1:0]    req_row, req_col;
  logic                accept, row_hit;

  assign req_row = req_addr[2*ROW_W-1:ROW_W];
  assign req_col = req_addr[ROW_W-1:0];
  assign accept  = req_valid & ready_q;
  assign row_hit = row_open_q & (req_row == open_row_q);

  dram_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Each branch computes the next state together with the pin values of that
  // next state, which keeps the command outputs registered and aligned with the state.
  always_comb begin
    // NOTE: every variable gets a default here so that no path infers a latch.
    state_d     = state_q;
    row_open_d  = row_open_q;
    open_row_d  = open_row_q;
    row_d       = row_q;
    col_d       = col_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    cmd_d       = CMD_NOP;
    a_d         = a_q;
    d_d         = '0;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        cmd_d   = CMD_DESEL;
        if (accept) begin
          ready_d = 1'b0;
          row_d   = req_row;
          col_d   = req_col;
          write_d = req_write;
          wdata_d = req_wdata;
          if (row_hit) begin
            state_d = req_write ? WRCMD : RDCMD;
            cmd_d   = req_write ? CMD_WR : CMD_RD;
            a_d     = req_col;
            d_d     = req_write ? req_wdata : '0;
          end else if (row_open_q) begin
            state_d    = PRE;
            cmd_d      = CMD_PRE;
            a_d        = open_row_q;
            row_open_d = 1'b0;
            tmr_load   = 1'b1;
            tmr_val    = TMR_W'(T_RP - 1);
          end else begin
            state_d  = ACT;
            cmd_d    = CMD_ACT;
            a_d      = req_row;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(T_RCD - 1);
          end
        end
      end
      PRE: begin
        if (tmr_zero) begin
          state_d  = ACT;
          cmd_d    = CMD_ACT;
          a_d      = row_q;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(T_RCD - 1);
        end
      end
      ACT: begin
        if (tmr_zero) begin
          row_open_d = 1'b1;
          open_row_d = row_q;
          state_d    = write_q ? WRCMD : RDCMD;
          cmd_d      = write_q ? CMD_WR : CMD_RD;
          a_d        = col_q;
          d_d        = write_q ? wdata_q : '0;
        end
      end
      RDCMD: begin
        state_d  = RDWAIT;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(T_CL - 1);
      end
      RDWAIT: begin
        if (tmr_zero) begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = DRAM_Q;
        end
      end
      WRCMD: begin
        state_d  = WRREC;
        tmr_load = 1'b1;
        tmr_val  = TMR_W'(T_WR - 1);
      end
      WRREC: begin
        if (tmr_zero) begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
        end
      end
      RSP: begin
        state_d = IDLE;
        cmd_d   = CMD_DESEL;
        ready_d = 1'b1;
      end
      default: begin
        state_d    = IDLE;
        row_open_d = 1'b0;
        cmd_d      = CMD_DESEL;
        ready_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      row_open_q  <= 1'b0;
      open_row_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      cmd_q       <= CMD_DESEL;
      a_q         <= '0;
      d_q         <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      row_open_q  <= row_open_d;
      open_row_q  <= open_row_d;
      row_q       <= row_d;
      col_q       <= col_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      cmd_q       <= cmd_d;
      a_q         <= a_d;
      d_q         <= d_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn} = cmd_q;
  assign DRAM_A    = a_q;
  assign DRAM_D    = d_q;
  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dram_cmd_seq.sv
// Bench for dram_cmd_seq: directed scenarios plus random traffic, checked against a latency and memory model.
// A second instance with all timing parameters set to 1 covers the zero-NOP corner case.
module tb_dram_cmd_seq;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam int P_RP = 2, P_RCD = 2, P_CL = 3, P_WR = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance (default timing)
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [21:0] req_addr = '0;
  logic [31:0] req_wdata = '0, DRAM_Q = '0;
  logic        req_ready, rsp_valid, DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn;
  logic [31:0] rsp_rdata, DRAM_D;
  logic [10:0] DRAM_A;

  dram_cmd_seq u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .DRAM_Q(DRAM_Q),
    .DRAM_CSn(DRAM_CSn), .DRAM_RASn(DRAM_RASn), .DRAM_CASn(DRAM_CASn),
    .DRAM_WEn(DRAM_WEn), .DRAM_A(DRAM_A), .DRAM_D(DRAM_D)
  );

  // Fast instance (all timing parameters = 1)
  logic        req_valid_f = 1'b0, req_write_f = 1'b0;
  logic [21:0] req_addr_f = '0;
  logic [31:0] req_wdata_f = '0;
  logic [31:0] DRAM_Q_f = 32'hA5A5_0001;
  logic        req_ready_f, rsp_valid_f, csn_f, rasn_f, casn_f, wen_f;
  logic [31:0] rsp_rdata_f, dram_d_f;
  logic [10:0] dram_a_f;

  dram_cmd_seq #(.T_RP(1), .T_RCD(1), .T_CL(1), .T_WR(1)) u_fast (
    .clk(clk), .rst(rst), .req_valid(req_valid_f), .req_ready(req_ready_f),
    .req_write(req_write_f), .req_addr(req_addr_f), .req_wdata(req_wdata_f),
    .rsp_valid(rsp_valid_f), .rsp_rdata(rsp_rdata_f), .DRAM_Q(DRAM_Q_f),
    .DRAM_CSn(csn_f), .DRAM_RASn(rasn_f), .DRAM_CASn(casn_f),
    .DRAM_WEn(wen_f), .DRAM_A(dram_a_f), .DRAM_D(dram_d_f)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] def_data(input logic [21:0] a);
    return ({10'h0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Pin log: each entry is keyed by the edge at which the DRAM samples the pins.
  logic [3:0]  cmd_log[int], cmd_log_f[int];
  logic [10:0] a_log[int], a_log_f[int];
  logic [31:0] d_log[int];

  // DRAM pin model: returns read data exactly T_CL edges after the RD edge, and garbage otherwise.
  typedef struct { int due; logic [31:0] data; } rd_t;
  rd_t         pend[$];
  logic [31:0] dram_mem[logic [21:0]];
  logic [10:0] dram_row = '0;

  always @(negedge clk) begin : mon
    int n;
    logic [3:0] c;
    logic [21:0] ad;
    rd_t r;
    n = cyc + 1;
    c = {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn};
    cmd_log[n] = c; a_log[n] = DRAM_A; d_log[n] = DRAM_D;
    cmd_log_f[n] = {csn_f, rasn_f, casn_f, wen_f}; a_log_f[n] = dram_a_f;
    if (!rst) pend.delete();
    else if (c == C_ACT) dram_row = DRAM_A;
    else if (c == C_WR) dram_mem[{dram_row, DRAM_A}] = DRAM_D;
    else if (c == C_RD) begin
      ad = {dram_row, DRAM_A};
      r.due = n + P_CL;
      r.data = dram_mem.exists(ad) ? dram_mem[ad] : def_data(ad);
      pend.push_back(r);
    end
    if (pend.size() > 0 && pend[0].due == n) begin
      DRAM_Q = pend[0].data;
      void'(pend.pop_front());
    end else begin
      DRAM_Q = $urandom;
    end
  end

  // Reference model: the open row and the memory contents, tracked one transaction at a time.
  bit          ref_open = 1'b0;
  logic [10:0] ref_row = '0;
  logic [31:0] ref_mem[logic [21:0]];

  function automatic logic [31:0] ref_rd(input logic [21:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : def_data(a);
  endfunction

  function automatic int exp_lat(input bit wr, input bit open, input bit hit,
                                 input int rp, input int rcd, input int cl, input int wrr);
    int l;
    l = wr ? 2 + wrr : 2 + cl;
    if (!open) l += rcd;
    else if (!hit) l += rp + rcd;
    return l;
  endfunction

  task automatic preload(input logic [21:0] a, input logic [31:0] v);
    dram_mem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic do_req(input bit wr, input logic [21:0] addr, input logic [31:0] wd,
                        output int e, output int lat, output logic [31:0] rd);
    int g;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    g = 0;
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    check("accept", req_ready, 1'b1);
    e = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 22'($urandom); req_wdata = $urandom; req_write = 1'($urandom);
    g = 0;
    while (!rsp_valid && g < 60) begin @(negedge clk); g++; end
    check("rsp_seen", rsp_valid, 1'b1);
    lat = cyc + 1 - e;
    rd = rsp_rdata;
    @(negedge clk);
    check("rsp_one_cycle", rsp_valid, 1'b0);
    check("ready_after_rsp", req_ready, 1'b1);
  endtask

  task automatic run_txn(input bit wr, input logic [21:0] addr, input logic [31:0] wd, output int e);
    int lat, xl;
    logic [31:0] rd;
    logic [10:0] row;
    row = addr[21:11];
    xl = exp_lat(wr, ref_open, ref_open && (ref_row == row), P_RP, P_RCD, P_CL, P_WR);
    do_req(wr, addr, wd, e, lat, rd);
    check(wr ? "wr_latency" : "rd_latency", lat, xl);
    if (wr) ref_mem[addr] = wd;
    else check("rd_data", rd, ref_rd(addr));
    ref_open = 1'b1;
    ref_row = row;
  endtask

  task automatic do_req_f(input logic [21:0] addr, output int e, output int lat, output logic [31:0] rd);
    int g;
    @(negedge clk);
    req_valid_f = 1'b1; req_write_f = 1'b0; req_addr_f = addr;
    g = 0;
    while (!req_ready_f && g < 50) begin @(negedge clk); g++; end
    check("fast_accept", req_ready_f, 1'b1);
    e = cyc + 1;
    @(negedge clk);
    req_valid_f = 1'b0;
    g = 0;
    while (!rsp_valid_f && g < 60) begin @(negedge clk); g++; end
    check("fast_rsp_seen", rsp_valid_f, 1'b1);
    lat = cyc + 1 - e;
    rd = rsp_rdata_f;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int e, lat, nr;
    logic [31:0] rd;
    logic [21:0] h_addr[3];
    bit          h_wr[3];
    logic [31:0] h_wd[3], h_exp[3], rsp_d[3];
    int          h_lat[3], acc_e[3], rsp_e[3];
    int          n_acc, n_rsp;
    bit          load_next;
    logic [10:0] row;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd", {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn}, 4'hF);
    check("rst_a", DRAM_A, 11'h0);
    check("rst_d", DRAM_D, 32'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_ready", req_ready, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Cold read
    preload({11'h005, 11'h010}, 32'hDEAD_BEEF);
    run_txn(1'b0, {11'h005, 11'h010}, 32'h0, e);
    check("cold_act_cmd", cmd_log[e+1], C_ACT);
    check("cold_act_a", a_log[e+1], 11'h005);
    check("cold_nop", cmd_log[e+2], C_NOP);
    check("cold_rd_cmd", cmd_log[e+3], C_RD);
    check("cold_rd_a", a_log[e+3], 11'h010);

    // Write on a row hit, then read back on a row hit
    run_txn(1'b1, {11'h005, 11'h011}, 32'h1234_5678, e);
    check("hitwr_cmd", cmd_log[e+1], C_WR);
    check("hitwr_a", a_log[e+1], 11'h011);
    check("hitwr_d", d_log[e+1], 32'h1234_5678);
    run_txn(1'b0, {11'h005, 11'h011}, 32'h0, e);
    check("hitrd_cmd_no_act", cmd_log[e+1], C_RD);

    // Row miss
    run_txn(1'b0, {11'h006, 11'h000}, 32'h0, e);
    check("miss_pre_cmd", cmd_log[e+1], C_PRE);
    check("miss_pre_a", a_log[e+1], 11'h005);
    check("miss_act_cmd", cmd_log[e+3], C_ACT);
    check("miss_act_a", a_log[e+3], 11'h006);
    check("miss_rd_cmd", cmd_log[e+5], C_RD);

    // Handshake: req_valid held high across three requests
    h_wr[0] = 1'b1; h_addr[0] = {11'h006, 11'h020}; h_wd[0] = 32'hAAAA_5555;
    h_wr[1] = 1'b0; h_addr[1] = {11'h006, 11'h020}; h_wd[1] = 32'h0;
    h_wr[2] = 1'b0; h_addr[2] = {11'h005, 11'h007}; h_wd[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      row = h_addr[i][21:11];
      h_lat[i] = exp_lat(h_wr[i], ref_open, ref_open && (ref_row == row), P_RP, P_RCD, P_CL, P_WR);
      h_exp[i] = 32'h0;
      if (h_wr[i]) ref_mem[h_addr[i]] = h_wd[i];
      else h_exp[i] = ref_rd(h_addr[i]);
      ref_open = 1'b1; ref_row = row;
    end
    n_acc = 0; n_rsp = 0; load_next = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = h_wr[0]; req_addr = h_addr[0]; req_wdata = h_wd[0];
    for (int g = 0; g < 200 && !(n_acc == 3 && n_rsp == 3); g++) begin
      if (rsp_valid && n_rsp < 3) begin rsp_e[n_rsp] = cyc + 1; rsp_d[n_rsp] = rsp_rdata; n_rsp++; end
      if (req_ready && n_acc < 3) begin acc_e[n_acc] = cyc + 1; n_acc++; load_next = 1'b1; end
      @(negedge clk);
      if (load_next) begin
        load_next = 1'b0;
        if (n_acc < 3) begin
          req_write = h_wr[n_acc]; req_addr = h_addr[n_acc]; req_wdata = h_wd[n_acc];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check("hs_acceptances", n_acc, 3);
    check("hs_responses", n_rsp, 3);
    if (n_acc == 3 && n_rsp == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("hs_latency", rsp_e[i] - acc_e[i], h_lat[i]);
        if (!h_wr[i]) check("hs_rdata", rsp_d[i], h_exp[i]);
      end
      check("hs_spacing01", acc_e[1] - acc_e[0], h_lat[0] + 1);
      check("hs_spacing12", acc_e[2] - acc_e[1], h_lat[1] + 1);
    end
    @(negedge clk);

    // Reset in the middle of RDWAIT
    req_valid = 1'b1; req_write = 1'b0; req_addr = {11'h005, 11'h030};
    check("rstmid_accept", req_ready, 1'b1);
    @(negedge clk); req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rstmid_csn", DRAM_CSn, 1'b1);
    check("rstmid_ready", req_ready, 1'b1);
    check("rstmid_rsp", rsp_valid, 1'b0);
    rst = 1'b1;
    ref_open = 1'b0;
    nr = 0;
    repeat (12) begin @(negedge clk); if (rsp_valid) nr++; end
    check("rstmid_no_rsp", nr, 0);
    run_txn(1'b0, {11'h005, 11'h010}, 32'h0, e);
    check("rstmid_act_not_pre", cmd_log[e+1], C_ACT);

    // Random traffic over a few rows, with small column ranges so that reads hit earlier writes
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(1'($urandom_range(0, 1)), {11'(5 + $urandom_range(0, 3)), 11'($urandom_range(0, 7))},
              $urandom, e);
    end

    // Minimum timing parameters: no NOP cycles on a row miss
    do_req_f({11'h001, 11'h002}, e, lat, rd);
    check("fast_cold_latency", lat, exp_lat(1'b0, 1'b0, 1'b0, 1, 1, 1, 1));
    @(negedge clk);
    do_req_f({11'h002, 11'h003}, e, lat, rd);
    check("fast_miss_latency", lat, exp_lat(1'b0, 1'b1, 1'b0, 1, 1, 1, 1));
    check("fast_pre", cmd_log_f[e+1], C_PRE);
    check("fast_pre_a", a_log_f[e+1], 11'h001);
    check("fast_act", cmd_log_f[e+2], C_ACT);
    check("fast_act_a", a_log_f[e+2], 11'h002);
    check("fast_rd", cmd_log_f[e+3], C_RD);
    check("fast_rd_a", a_log_f[e+3], 11'h003);
    check("fast_rdata", rd, 32'hA5A5_0001);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
